// File: rtl/debug_pkg.sv
// Shared constants for the debug responder: command opcodes, register map and FSM states.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package debug_pkg;

    // Command opcodes, held in CMD[3:0]
    localparam logic [3:0] OP_HALT      = 4'd0;
    localparam logic [3:0] OP_RUN       = 4'd1;
    localparam logic [3:0] OP_STEP      = 4'd2;
    localparam logic [3:0] OP_READ_REG  = 4'd3;
    localparam logic [3:0] OP_WRITE_REG = 4'd4;
    localparam logic [3:0] OP_READ_MEM  = 4'd5;
    localparam logic [3:0] OP_WRITE_MEM = 4'd6;

    // Debug register map, selected by dbg_addr
    localparam logic [1:0] ADDR_CMD     = 2'd0;
    localparam logic [1:0] ADDR_ADDRESS = 2'd1;
    localparam logic [1:0] ADDR_DATA    = 2'd2;
    localparam logic [1:0] ADDR_RESULT  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXEC,
        ST_WAIT_STOP,
        ST_MEM,
        ST_ACK,
        ST_DRAIN
    } state_t;

endpackage

// File: rtl/debug_responder.sv
// Debug command responder: 4-register debug bank driving CPU run/step, the register-file port and a 32-bit memory master.
// Latency: req->ack 2 cycles (RUN/REG/unknown), 3 for HALT/STEP once stopped, 3 + mem_ack wait for memory commands.
// Backpressure: dbg_req is level-held until dbg_ack; the FSM drains until req drops, and memory waits on mem_ack indefinitely.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   dbg_addr/din/dout/wr_en        debug register access (CMD, ADDRESS, DATA, RESULT)
//   dbg_req, dbg_ack               command handshake (level request, one-cycle ack)
//   run, stopped, step             CPU run control
//   reg_sel/wr_val/wr_en/rd_val    CPU register-file port
//   mem_addr/wdata/rdata/wr_en/access/ack   memory master
module debug_responder
    import debug_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  dbg_addr,
    input  logic [31:0] dbg_din,
    output logic [31:0] dbg_dout,
    input  logic        dbg_wr_en,
    input  logic        dbg_req,
    output logic        dbg_ack,
    output logic        run,
    input  logic        stopped,
    output logic        step,
    output logic [3:0]  reg_sel,
    output logic [31:0] reg_wr_val,
    output logic        reg_wr_en,
    input  logic [31:0] reg_rd_val,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        mem_wr_en,
    output logic        mem_access,
    input  logic        mem_ack
);

    state_t      state;
    logic [3:0]  cmd_q;
    logic [3:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [31:0] result_q;

    assign reg_sel    = addr_q[3:0];
    assign reg_wr_val = data_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = data_q;

    always_comb begin
        dbg_dout = 32'd0;
        case (dbg_addr)
            ADDR_CMD:     dbg_dout = {31'd0, stopped};
            ADDR_ADDRESS: dbg_dout = addr_q;
            ADDR_DATA:    dbg_dout = data_q;
            ADDR_RESULT:  dbg_dout = result_q;
            default:      dbg_dout = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cmd_q      <= 4'd0;
            op_q       <= 4'd0;
            addr_q     <= 32'd0;
            data_q     <= 32'd0;
            result_q   <= 32'd0;
            run        <= 1'b1;
            step       <= 1'b0;
            reg_wr_en  <= 1'b0;
            mem_access <= 1'b0;
            mem_wr_en  <= 1'b0;
            dbg_ack    <= 1'b0;
        end else begin
            // Single-cycle pulses default low every cycle.
            step      <= 1'b0;
            reg_wr_en <= 1'b0;
            dbg_ack   <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (dbg_wr_en) begin
                        case (dbg_addr)
                            ADDR_CMD:     cmd_q  <= dbg_din[3:0];
                            ADDR_ADDRESS: addr_q <= dbg_din;
                            ADDR_DATA:    data_q <= dbg_din;
                            default:      ; // RESULT is read-only
                        endcase
                    end
                    if (dbg_req) begin
                        op_q  <= cmd_q;
                        state <= ST_EXEC;
                        // Pulses that belong to the EXEC cycle are launched on
                        // entry so they are registered yet line up with EXEC.
                        // run only changes inside EXEC, so its value here is
                        // the value EXEC will see.
                        step      <= (cmd_q == OP_STEP) && !run;
                        reg_wr_en <= (cmd_q == OP_WRITE_REG);
                    end
                end

                ST_EXEC: begin
                    case (op_q)
                        OP_HALT: begin
                            run   <= 1'b0;
                            state <= ST_WAIT_STOP;
                        end
                        OP_RUN: begin
                            run     <= 1'b1;
                            state   <= ST_ACK;
                            dbg_ack <= 1'b1;
                        end
                        OP_STEP: begin
                            if (!run) begin
                                state <= ST_WAIT_STOP;
                            end else begin
                                state   <= ST_ACK;
                                dbg_ack <= 1'b1;
                            end
                        end
                        OP_READ_REG: begin
                            result_q <= reg_rd_val;
                            state    <= ST_ACK;
                            dbg_ack  <= 1'b1;
                        end
                        OP_READ_MEM, OP_WRITE_MEM: begin
                            mem_access <= 1'b1;
                            mem_wr_en  <= (op_q == OP_WRITE_MEM);
                            state      <= ST_MEM;
                        end
                        default: begin
                            // WRITE_REG already pulsed; unknown opcodes do nothing.
                            state   <= ST_ACK;
                            dbg_ack <= 1'b1;
                        end
                    endcase
                end

                ST_WAIT_STOP: begin
                    if (stopped) begin
                        state   <= ST_ACK;
                        dbg_ack <= 1'b1;
                    end
                end

                ST_MEM: begin
                    if (mem_ack) begin
                        if (!mem_wr_en) begin
                            result_q <= mem_rdata;
                        end
                        mem_access <= 1'b0;
                        mem_wr_en  <= 1'b0;
                        state      <= ST_ACK;
                        dbg_ack    <= 1'b1;
                    end
                end

                ST_ACK: begin
                    state <= ST_DRAIN;
                end

                ST_DRAIN: begin
                    // Wait for the initiator to drop the request so a held
                    // level cannot start a second command.
                    if (!dbg_req) begin
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debug_responder.sv
`timescale 1ns/1ps
module tb_debug_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  dbg_addr;
    logic [31:0] dbg_din;
    logic [31:0] dbg_dout;
    logic        dbg_wr_en;
    logic        dbg_req;
    logic        dbg_ack;
    logic        run;
    logic        stopped;
    logic        step;
    logic [3:0]  reg_sel;
    logic [31:0] reg_wr_val;
    logic        reg_wr_en;
    logic [31:0] reg_rd_val;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_wr_en;
    logic        mem_access;
    logic        mem_ack;

    debug_responder dut (
        .clk        (clk),
        .rst        (rst),
        .dbg_addr   (dbg_addr),
        .dbg_din    (dbg_din),
        .dbg_dout   (dbg_dout),
        .dbg_wr_en  (dbg_wr_en),
        .dbg_req    (dbg_req),
        .dbg_ack    (dbg_ack),
        .run        (run),
        .stopped    (stopped),
        .step       (step),
        .reg_sel    (reg_sel),
        .reg_wr_val (reg_wr_val),
        .reg_wr_en  (reg_wr_en),
        .reg_rd_val (reg_rd_val),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_wr_en  (mem_wr_en),
        .mem_access (mem_access),
        .mem_ack    (mem_ack)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Results of the last command run by run_cmd
    int          lat, acks, steps, wrs, maccs, mwrs;
    logic [31:0] last_maddr, last_wdata;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // All drivers change at a negedge; the DUT samples at the posedge between.
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        dbg_addr  = a;
        dbg_din   = d;
        dbg_wr_en = 1'b1;
        @(negedge clk);
        dbg_wr_en = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
        dbg_addr = a;
        #1;
        check(tag, dbg_dout, exp);
    endtask

    // Raise dbg_req and watch the command. lat = number of rising edges from
    // the one that samples req to the one after which dbg_ack is seen.
    // stop_at: iteration at which stopped is raised (0 = leave alone).
    // mem_delay: mem_ack is raised after this many cycles of mem_access.
    // hold: extra cycles req stays high after the ack.
    // poke: try an ADDRESS write during the first MEM cycle.
    task automatic run_cmd(input int stop_at, input int mem_delay, input int hold, input bit poke);
        int i;
        int post;
        bit done;
        lat = 0; acks = 0; steps = 0; wrs = 0; maccs = 0; mwrs = 0;
        last_maddr = 32'd0; last_wdata = 32'd0;
        mem_ack = 1'b0;
        dbg_req = 1'b1;
        i = 0; post = 0; done = 1'b0;
        while (!done && i < 200) begin
            i++;
            if (i == stop_at) stopped = 1'b1;
            @(negedge clk);
            dbg_wr_en = 1'b0;
            if (dbg_ack) acks++;
            if (step) steps++;
            if (reg_wr_en) wrs++;
            if (dbg_ack && lat == 0) lat = i;
            if (mem_access) begin
                maccs++;
                if (mem_wr_en) mwrs++;
                last_maddr = mem_addr;
                last_wdata = mem_wdata;
                mem_ack = (maccs == mem_delay);
                if (poke && maccs == 1) begin
                    dbg_addr  = 2'd1;
                    dbg_din   = 32'hFFFF_FFFF;
                    dbg_wr_en = 1'b1;
                end
            end else begin
                mem_ack = 1'b0;
            end
            if (lat != 0) begin
                post++;
                if (post == hold + 1) dbg_req = 1'b0;
                if (post == hold + 4) done = 1'b1;
            end
        end
        dbg_req   = 1'b0;
        dbg_wr_en = 1'b0;
        mem_ack   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; dbg_addr = 2'd0; dbg_din = 32'd0; dbg_wr_en = 1'b0; dbg_req = 1'b0;
        stopped = 1'b0; reg_rd_val = 32'd0; mem_rdata = 32'd0; mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_run", {31'd0, run}, 32'd1);
        check("rst_step", {31'd0, step}, 32'd0);
        check("rst_reg_wr_en", {31'd0, reg_wr_en}, 32'd0);
        check("rst_mem_access", {31'd0, mem_access}, 32'd0);
        check("rst_mem_wr_en", {31'd0, mem_wr_en}, 32'd0);
        check("rst_ack", {31'd0, dbg_ack}, 32'd0);
        rd(2'd0, 32'd0, "rst_status");
        rd(2'd1, 32'd0, "rst_address");
        rd(2'd2, 32'd0, "rst_data");
        rd(2'd3, 32'd0, "rst_result");

        // READ_REG: ack two edges after req, RESULT captures the CPU register
        wr(2'd1, 32'd5);
        wr(2'd0, 32'd3);
        reg_rd_val = 32'hDEAD_BEEF;
        check("rr_reg_sel", {28'd0, reg_sel}, 32'd5);
        run_cmd(0, 0, 0, 1'b0);
        check("rr_latency", lat, 2);
        check("rr_acks", acks, 1);
        rd(2'd3, 32'hDEAD_BEEF, "rr_result");

        // HALT with stopped low for 10 cycles, then stopped -> ack next cycle
        stopped = 1'b0;
        wr(2'd0, 32'd0);
        run_cmd(11, 0, 0, 1'b0);
        check("halt_latency", lat, 11);
        check("halt_acks", acks, 1);
        check("halt_run", {31'd0, run}, 32'd0);
        rd(2'd0, 32'd1, "halt_status");

        // STEP while halted: one pulse, ack waits for stopped
        stopped = 1'b0;
        wr(2'd0, 32'd2);
        run_cmd(5, 0, 0, 1'b0);
        check("step0_pulses", steps, 1);
        check("step0_latency", lat, 5);
        check("step0_acks", acks, 1);

        // WRITE_REG: single reg_wr_en pulse with ADDRESS/DATA on the port
        wr(2'd2, 32'hA5A5_0001);
        wr(2'd1, 32'd7);
        wr(2'd0, 32'd4);
        run_cmd(0, 0, 0, 1'b0);
        check("wreg_latency", lat, 2);
        check("wreg_pulses", wrs, 1);
        check("wreg_sel", {28'd0, reg_sel}, 32'd7);
        check("wreg_val", reg_wr_val, 32'hA5A5_0001);

        // RUN
        wr(2'd0, 32'd1);
        run_cmd(0, 0, 0, 1'b0);
        check("run_latency", lat, 2);
        check("run_run", {31'd0, run}, 32'd1);

        // STEP while running: no pulse, ack at +2
        wr(2'd0, 32'd2);
        run_cmd(0, 0, 0, 1'b0);
        check("step1_latency", lat, 2);
        check("step1_pulses", steps, 0);

        // WRITE_MEM with mem_ack after 4 access cycles, req held 5 cycles
        // past the ack, and an ADDRESS write attempted during MEM
        wr(2'd1, 32'h0000_1000);
        wr(2'd2, 32'h1234_5678);
        wr(2'd0, 32'd6);
        run_cmd(0, 4, 5, 1'b1);
        check("wmem_latency", lat, 6);
        check("wmem_acks", acks, 1);
        check("wmem_access_cycles", maccs, 4);
        check("wmem_wr_cycles", mwrs, 4);
        check("wmem_addr", last_maddr, 32'h0000_1000);
        check("wmem_wdata", last_wdata, 32'h1234_5678);
        rd(2'd1, 32'h0000_1000, "wmem_address_kept");
        // Back in IDLE: writes take effect again
        wr(2'd1, 32'h0000_0055);
        rd(2'd1, 32'h0000_0055, "idle_after_drain");

        // READ_MEM with immediate mem_ack
        wr(2'd1, 32'h0000_2000);
        wr(2'd0, 32'd5);
        mem_rdata = 32'hCAFE_F00D;
        run_cmd(0, 1, 0, 1'b0);
        check("rmem_latency", lat, 3);
        check("rmem_wr_cycles", mwrs, 0);
        rd(2'd3, 32'hCAFE_F00D, "rmem_result");

        // Unknown opcode
        wr(2'd0, 32'd9);
        run_cmd(0, 0, 0, 1'b0);
        check("unk_latency", lat, 2);
        check("unk_steps", steps + wrs + maccs, 0);

        // HALT with stopped already high
        stopped = 1'b1;
        wr(2'd0, 32'd0);
        run_cmd(0, 0, 0, 1'b0);
        check("halt1_latency", lat, 3);
        check("halt1_run", {31'd0, run}, 32'd0);

        // Reset during MEM abandons the access without an ack
        wr(2'd1, 32'h0000_3000);
        wr(2'd2, 32'h0000_00AA);
        wr(2'd0, 32'd5);
        mem_ack = 1'b0;
        dbg_req = 1'b1;
        repeat (3) @(negedge clk);
        check("mrst_access_before", {31'd0, mem_access}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mrst_access", {31'd0, mem_access}, 32'd0);
        check("mrst_ack", {31'd0, dbg_ack}, 32'd0);
        check("mrst_run", {31'd0, run}, 32'd1);
        rd(2'd1, 32'd0, "mrst_address");
        rd(2'd2, 32'd0, "mrst_data");
        rd(2'd3, 32'd0, "mrst_result");
        rst = 1'b0;
        dbg_req = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("mrst_no_ack", {31'd0, dbg_ack}, 32'd0);
        end

        // CMD was cleared by reset, so a bare request performs HALT
        stopped = 1'b1;
        run_cmd(0, 0, 0, 1'b0);
        check("mrst_cmd_halt_latency", lat, 3);
        check("mrst_cmd_halt_run", {31'd0, run}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
